uart_cmd_bridge: RTL and testbench
==================================

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max idle cycles between bytes of one command frame.
REQ-002 SHALL have port clk  input  1  single system clock (clk_sys domain); all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  byte from UART receiver (data_out).
REQ-005 SHALL have port rx_valid  input  1  one-cycle pulse, rx_data valid (data_received).
REQ-006 SHALL have port tx_data  output  8  byte to UART transmitter (data_in).
REQ-007 SHALL have port tx_send  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-008 SHALL have port tx_sent  input  1  one-cycle pulse, transmitter finished current byte.
REQ-009 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32: memory request.
REQ-010 SHALL have ports mem_rdata  input  32, mem_ack  input  1: memory completion.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port overrun  output  1  sticky: a byte was dropped.

Function
REQ-013 SHALL decode frames: 0x57 'W' + 4 address bytes + 4 data bytes = write; 0x52 'R' + 4 address bytes = read; multi-byte fields big-endian (MSB first).
REQ-014 SHALL use states IDLE, ADDR, DATA, MEM, TX, TX_WAIT.
REQ-015 IDLE: 'W'/'R' -> ADDR with byte counter 0; any other byte -> TX with response 0x15 (NAK).
REQ-016 ADDR: shift byte into address; after 4th byte -> DATA (write) or MEM (read).
REQ-017 DATA: shift byte into wdata; after 4th byte -> MEM.
REQ-018 MEM: mem_req registered high the cycle after entry, mem_addr/mem_we/mem_wdata stable while req high; on mem_ack drop req next cycle, capture mem_rdata on reads.
REQ-019 mem_ack while mem_req low SHALL be ignored; ack in first cycle req is high SHALL be accepted.
REQ-020 Response after MEM: write -> single byte 0x06 (ACK); read -> 4 bytes of captured rdata, MSB first.
REQ-021 TX: drive tx_data, pulse tx_send one cycle, -> TX_WAIT; TX_WAIT on tx_sent -> TX if bytes remain, else IDLE.
REQ-022 At most one byte outstanding to the transmitter; tx_send never pulses again before tx_sent.
REQ-023 Timeout counter SHALL clear on each rx_valid and on entering ADDR; in ADDR/DATA reaching TIMEOUT_CYCLES -> IDLE silently, partial frame discarded, no memory access.
REQ-024 rx_valid in MEM/TX/TX_WAIT SHALL drop the byte and set overrun; overrun cleared only by rst.
REQ-025 rx_valid and timeout expiry in same cycle: byte wins, counter clears.
REQ-026 Address arithmetic none; mem_addr passed verbatim, no alignment check.

Reset
REQ-027 On rst sampled high: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, tx_send 0, tx_data 0, busy 0, overrun 0, counters 0.
REQ-028 rst mid-transaction SHALL abandon the memory request and pending transmission with no further pulses.

Structure
REQ-029 Package uart_cmd_pkg SHALL hold command/response byte constants (0x57, 0x52, 0x06, 0x15) and state encoding.
REQ-030 Inter-byte timeout SHALL be a sub-module uart_cmd_timeout (clear, enable, expired).

Verification
REQ-031 Frame 57 00 00 01 00 DE AD BE EF -> one mem_req, we=1, addr 0x00000100, wdata 0xDEADBEEF; then tx 0x06.
REQ-032 Frame 52 00 00 01 00, memory returns 0xCAFEF00D after 3 cycles -> we=0, tx 0xCA 0xFE 0xF0 0x0D in order, each after tx_sent.
REQ-033 Byte 0x41 in IDLE -> tx 0x15, no mem_req, back to IDLE.
REQ-034 TIMEOUT_CYCLES=16, send 57 00 then 20 idle cycles -> IDLE, no mem_req; subsequent valid read frame completes normally.
REQ-035 rx_valid during MEM stall -> overrun=1, frame result unchanged; rst mid-MEM -> mem_req 0 next cycle, overrun 0.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command bridge: command/response byte
// values and the FSM state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W' + addr[4] + data[4]
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R' + addr[4]
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    MEM     = 3'd3,
    TX      = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count (new byte / not collecting a frame)
//   enable   : count while a frame is being collected
//   expired  : count has reached TIMEOUT_CYCLES while enabled
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  assign expired = enable && (cnt >= W'(TIMEOUT_CYCLES));

  // Saturates at the limit so a stalled enable never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (enable && (cnt < W'(TIMEOUT_CYCLES)))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: decodes 'W'/'R' frames from a byte stream into single
// 32-bit memory accesses and streams the response back byte by byte.
//   clk, rst            : clock, synchronous active-high reset
//   rx_data/rx_valid    : received byte + one-cycle strobe
//   tx_data/tx_send     : byte to transmit + one-cycle request
//   tx_sent             : transmitter done with current byte
//   mem_req/we/addr/wdata, mem_rdata/mem_ack : memory request/completion
//   busy                : FSM not idle
//   overrun             : sticky, a byte arrived while it could not be taken
module uart_cmd_bridge
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_sent,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        overrun
);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic        is_write;
  logic [31:0] tx_buf;    // response bytes, next one in [31:24]
  logic [2:0]  tx_left;   // bytes still to hand to the transmitter
  logic        collecting;
  logic        expired;

  assign collecting = (state == ADDR) || (state == DATA);
  assign busy       = (state != IDLE);

  uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid || !collecting),
    .enable  (collecting),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      is_write  <= 1'b0;
      tx_buf    <= '0;
      tx_left   <= '0;
      tx_data   <= '0;
      tx_send   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      overrun   <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      if (rx_valid && (state == MEM || state == TX || state == TX_WAIT))
        overrun <= 1'b1;

      case (state)
        IDLE: if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            is_write <= (rx_data == CMD_WRITE);
            byte_cnt <= '0;
            state    <= ADDR;
          end else begin
            tx_buf  <= {RSP_NAK, 24'h0};
            tx_left <= 3'd1;
            state   <= TX;
          end
        end

        // A received byte takes priority over a same-cycle timeout.
        ADDR: if (rx_valid) begin
          mem_addr <= {mem_addr[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            mem_we <= is_write;
            state  <= is_write ? DATA : MEM;
          end
        end else if (expired) begin
          state <= IDLE;
        end

        DATA: if (rx_valid) begin
          mem_wdata <= {mem_wdata[23:0], rx_data};
          byte_cnt  <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            mem_we <= is_write;
            state  <= MEM;
          end
        end else if (expired) begin
          state <= IDLE;
        end

        // Request rises one cycle after entry; an ack is only honoured once
        // the request is visible, so stray acks are ignored.
        MEM: if (!mem_req) begin
          mem_req <= 1'b1;
        end else if (mem_ack) begin
          mem_req <= 1'b0;
          state   <= TX;
          if (is_write) begin
            tx_buf  <= {RSP_ACK, 24'h0};
            tx_left <= 3'd1;
          end else begin
            tx_buf  <= mem_rdata;
            tx_left <= 3'd4;
          end
        end

        TX: begin
          tx_data <= tx_buf[31:24];
          tx_send <= 1'b1;
          tx_buf  <= {tx_buf[23:0], 8'h00};
          tx_left <= tx_left - 3'd1;
          state   <= TX_WAIT;
        end

        TX_WAIT: if (tx_sent)
          state <= (tx_left == 3'd0) ? IDLE : TX;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
module tb_uart_cmd_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_sent;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        overrun;

  int errs = 0;
  int checks = 0;
  int req_cnt = 0;
  logic req_q = 1'b0;
  logic exp_ovr = 1'b0;

  uart_cmd_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_sent(tx_sent),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Count distinct memory requests (rising edges of mem_req).
  always @(negedge clk) begin
    if (mem_req && !req_q) req_cnt <= req_cnt + 1;
    req_q <= mem_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = $urandom;
  endtask

  // Waits for one tx_send pulse, checks the byte, holds off tx_sent for a
  // random time (no second pulse allowed), then acknowledges it.
  task automatic take_tx(input string tag, input logic [7:0] exp);
    int n = 0;
    int extra = 0;
    while (!tx_send && n < 40) begin tick(); n++; end
    chk({tag, "_send"}, 32'(tx_send), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(exp));
    repeat ($urandom_range(1, 4)) begin
      tick();
      if (tx_send) extra++;
    end
    chk({tag, "_early"}, extra, 0);
    tx_sent = 1'b1;
    tick();
    tx_sent = 1'b0;
  endtask

  // One command frame against the reference: a write answers ACK, a read
  // answers the four returned data bytes MSB first. stall<0 picks random.
  task automatic run_frame(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input int stall, input bit ovr);
    logic [7:0] fb[$];
    logic [7:0] exp_tx[$];
    int n, base, st;
    base = req_cnt;
    fb.push_back(wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) fb.push_back(a[i*8 +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) fb.push_back(d[i*8 +: 8]);
    if (wr) exp_tx.push_back(8'h06);
    else for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[i*8 +: 8]);

    foreach (fb[i]) begin
      send_byte(fb[i]);
      if (i != fb.size() - 1) begin
        int g = $urandom_range(0, 3);
        if (g > 0 && $urandom_range(0, 1) == 1) begin
          // stray ack while no request is up: must be ignored
          mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
          tick();
          mem_ack = 1'b0;
          g--;
        end
        idle(g);
      end
    end

    n = 0;
    while (!mem_req && n < 40) begin tick(); n++; end
    chk("mem_req_seen", 32'(mem_req), 32'd1);
    if (!mem_req) return;
    chk("mem_we", 32'(mem_we), 32'(wr));
    chk("mem_addr", mem_addr, a);
    if (wr) chk("mem_wdata", mem_wdata, d);

    st = (stall < 0) ? $urandom_range(0, 3) : stall;
    if (ovr && st == 0) st = 1;
    for (int j = 0; j < st; j++) begin
      if (ovr && j == 0) begin
        send_byte(8'h57);
        exp_ovr = 1'b1;
      end else tick();
      chk("req_hold", 32'(mem_req), 32'd1);
      chk("addr_hold", mem_addr, a);
    end
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0; mem_rdata = $urandom;
    chk("mem_req_drop", 32'(mem_req), 32'd0);

    foreach (exp_tx[i]) take_tx($sformatf("tx%0d", i), exp_tx[i]);
    idle(2);
    chk("busy_end", 32'(busy), 32'd0);
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    chk("req_count", req_cnt - base, 1);
  endtask

  initial begin
    int base;
    logic [7:0] b;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_sent = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;
    idle(3);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_tx_send", 32'(tx_send), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    idle(2);

    // directed write and read
    run_frame(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, -1, 1'b0);
    run_frame(1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 3, 1'b0);
    run_frame(1'b0, 32'h0000_0003, 32'h0, 32'h1234_5678, 0, 1'b0);

    // unknown command byte -> NAK, no memory access
    base = req_cnt;
    send_byte(8'h41);
    take_tx("nak", 8'h15);
    idle(2);
    chk("nak_busy", 32'(busy), 0);
    chk("nak_req_count", req_cnt - base, 0);

    // partial frame times out silently
    base = req_cnt;
    send_byte(8'h57);
    idle(2);
    send_byte(8'h00);
    idle(20);
    chk("to_busy", 32'(busy), 0);
    chk("to_req_count", req_cnt - base, 0);
    run_frame(1'b0, 32'h8000_0004, 32'h0, 32'h0BAD_CAFE, -1, 1'b0);

    // random frames, including random non-command bytes
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        base = req_cnt;
        send_byte(b);
        take_tx("rnd_nak", 8'h15);
        idle(1);
        chk("rnd_nak_req", req_cnt - base, 0);
      end else begin
        run_frame(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, -1, 1'b0);
      end
    end

    // byte dropped during a memory stall
    run_frame(1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_5A5A, 2, 1'b1);
    run_frame(1'b1, $urandom, $urandom, 32'h0, -1, 1'b0);

    // reset while the memory request is up
    send_byte(8'h57);
    repeat (8) send_byte(8'($urandom));
    base = 0;
    while (!mem_req && base < 40) begin tick(); base++; end
    chk("rstmem_req_up", 32'(mem_req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmem_req", 32'(mem_req), 0);
    chk("rstmem_ovr", 32'(overrun), 0);
    chk("rstmem_busy", 32'(busy), 0);
    exp_ovr = 1'b0;
    base = 0;
    repeat (10) begin
      tick();
      if (tx_send || mem_req) base++;
    end
    chk("rstmem_quiet", base, 0);

    for (int k = 0; k < 5; k++)
      run_frame(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
